// File: rtl/cpu_req_queue_pkg.sv
// Shared types for the CPU request queue sitting in front of the cache controller:
// CPU/cache interface structs, the queued entry layout and the queue FSM states.
package cpu_req_queue_pkg;

  localparam int CACHE_ADDR_W = 32;
  localparam int CACHE_DATA_W = 32;

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_DATA_W-1:0] data;
    logic                    rw;
    logic                    valid;
  } cpu_to_cache_type;

  typedef struct packed {
    logic [CACHE_DATA_W-1:0] data;
    logic                    ready;
  } cache_to_cpu_type;

  typedef struct packed {
    logic                    rw;
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_DATA_W-1:0] data;
  } cpu_req_entry_type;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } req_queue_state_type;

endpackage

// File: rtl/cpu_req_queue_sync_fifo.sv
// Single-clock FIFO with a combinational head read, so the oldest entry can be
// loaded into an output register on the same edge that pops it.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cpu_req_queue.sv
// CPU request buffer: queues load/store requests, issues them one at a time to the
// cache with a valid gap between accesses, and returns read data in order.
module cpu_req_queue
  import cpu_req_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output cpu_to_cache_type  cpu_to_cache,
  input  cache_to_cpu_type  cache_to_cpu,
  output logic              busy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = $bits(cpu_req_entry_type);

  cpu_req_entry_type   entry_in;
  cpu_req_entry_type   head;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [PTR_W:0]      fifo_count;

  req_queue_state_type state_reg;
  req_queue_state_type state_next;
  logic                load_req;
  logic                complete_req;

  cpu_to_cache_type    cpu_to_cache_reg;
  logic                resp_valid_reg;
  logic [DATA_W-1:0]   resp_data_reg;

  assign entry_in  = '{rw: req_rw, addr: req_addr, data: req_data};
  assign req_ready = !fifo_full;
  assign push      = req_valid && req_ready;
  assign pop       = load_req;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (entry_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   if (cache_to_cpu.ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready in IDLE is ignored; completion only counts while a request is presented.
  always_comb begin
    load_req     = 1'b0;
    complete_req = 1'b0;
    unique case (state_reg)
      IDLE:    load_req     = !fifo_empty;
      ISSUE:   complete_req = cache_to_cpu.ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_to_cache_reg <= '0;
      resp_valid_reg   <= 1'b0;
      resp_data_reg    <= '0;
    end else begin
      resp_valid_reg <= 1'b0;
      if (load_req) begin
        cpu_to_cache_reg <= '{addr: head.addr, data: head.data, rw: head.rw, valid: 1'b1};
      end else if (complete_req) begin
        cpu_to_cache_reg.valid <= 1'b0;
        if (!cpu_to_cache_reg.rw) begin
          resp_valid_reg <= 1'b1;
          resp_data_reg  <= cache_to_cpu.data;
        end
      end
    end
  end

  assign cpu_to_cache = cpu_to_cache_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_data    = resp_data_reg;
  assign busy         = (fifo_count != '0) || (state_reg == ISSUE);

endmodule

// File: tb/tb_cpu_req_queue.sv
// Randomised scoreboard bench for cpu_req_queue: a program-order memory model predicts
// cache traffic and read responses; a monitor plays the cache and checks each cycle.
module tb_cpu_req_queue;
  import cpu_req_queue_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_rw = 1'b0;
  logic [31:0]      req_addr = '0;
  logic [31:0]      req_data = '0;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic             busy;
  cpu_to_cache_type c2c;
  cache_to_cpu_type c2p = '0;

  always #5 clk = ~clk;

  cpu_req_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .cpu_to_cache (c2c),
    .cache_to_cpu (c2p),
    .busy         (busy)
  );

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  req_t        exp_req[$];
  logic [31:0] exp_resp[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] cache_mem[logic [31:0]];
  int          n_acc = 0, n_issue = 0, n_resp = 0;
  int          last_acc_cyc = 0, last_issue_cyc = 0, last_held = 0;
  int          lat_mode = 0;
  bit          stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] cache_read(input logic [31:0] a);
    return cache_mem.exists(a) ? cache_mem[a] : init_val(a);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit rw, input logic [31:0] addr, input logic [31:0] data);
    int waited = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_data  = data;
    while (!req_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", req_ready, 1'b1);
    if (req_ready) begin
      exp_req.push_back('{rw, addr, data});
      if (rw) ref_mem[addr] = data;
      else    exp_resp.push_back(ref_read(addr));
      n_acc++;
      last_acc_cyc = cyc + 1;
      $display("req  %s addr=%h data=%h", rw ? "WR" : "RD", addr, data);
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    while ((busy || exp_req.size() != 0 || exp_resp.size() != 0) && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_pending_resp", exp_resp.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
  endtask

  // Cache model + monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    req_t cur;
    int   lat = 0, held = 0, occ = 0, occ_prev = 0;
    bit   inflight = 1'b0, rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_cpu_to_cache", c2c, '0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, '0);
        inflight = 1'b0;
        rdy      = 1'b0;
        c2p      = '0;
        occ_prev = 0;
        n_acc    = 0;
        n_issue  = 0;
        exp_req.delete();
        exp_resp.delete();
        ref_mem = cache_mem;
      end else begin
        if (resp_valid) begin
          n_resp++;
          $display("resp data=%h", resp_data);
          if (exp_resp.size() == 0) chk("unexpected_resp", resp_valid, 1'b0);
          else chk("resp_data", resp_data, exp_resp.pop_front());
        end
        if (rdy) begin
          chk("valid_gap", c2c.valid, 1'b0);
          c2p       = '0;
          rdy       = 1'b0;
          inflight  = 1'b0;
          last_held = held;
          if (cur.rw) cache_mem[cur.addr] = cur.data;
        end else if (inflight) begin
          held++;
          chk("held_req", {c2c.valid, c2c.rw, c2c.addr, c2c.data},
              {1'b1, cur.rw, cur.addr, cur.data});
        end else begin
          chk("issue_valid", c2c.valid, occ_prev > 0);
          if (c2c.valid) begin
            if (exp_req.size() == 0) begin
              chk("unexpected_issue", c2c.valid, 1'b0);
              cur = '{c2c.rw, c2c.addr, c2c.data};
            end else begin
              cur = exp_req.pop_front();
              chk("issue_req", {c2c.rw, c2c.addr, c2c.data}, {cur.rw, cur.addr, cur.data});
            end
            inflight       = 1'b1;
            held           = 1;
            n_issue++;
            last_issue_cyc = cyc;
            lat            = (lat_mode > 0) ? lat_mode : int'($urandom_range(1, 4));
          end
        end
        if (inflight && !rdy) begin
          if (lat > 0) lat--;
          if (lat == 0 && !stall) begin
            c2p.ready = 1'b1;
            c2p.data  = cur.rw ? $urandom : cache_read(cur.addr);
            rdy       = 1'b1;
          end
        end
        occ = n_acc - n_issue;
        chk("req_ready", req_ready, occ < DEPTH);
        chk("busy", busy, (occ != 0) || inflight);
        occ_prev = occ;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single read with a 5-cycle cache access
    lat_mode = 5;
    cache_mem[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40]   = 32'hDEAD_BEEF;
    r0 = n_resp;
    send(1'b0, 32'h40, 32'h0);
    wait_idle(100);
    chk("t1_rise_after_enqueue", last_issue_cyc - last_acc_cyc, 1);
    chk("t1_valid_held", last_held, 5);
    chk("t1_resp_count", n_resp - r0, 1);

    // Posted writes against a stalled cache, then fill and hold a request while full
    lat_mode = 2;
    stall    = 1'b1;
    r0       = n_resp;
    for (int i = 0; i < 4; i++) send(1'b1, 32'h10 + 32'(4 * i), 32'(i + 1));
    send(1'b0, 32'h20, 32'h0);
    chk("t2_full_ready", req_ready, 1'b0);
    fork
      send(1'b0, 32'h24, 32'h0);
      begin
        repeat (4) @(negedge clk);
        stall = 1'b0;
      end
    join
    chk("t2_accept_after_pop", last_acc_cyc - last_issue_cyc, 1);
    wait_idle(200);
    chk("t2_resp_count", n_resp - r0, 2);

    // Mixed write/read ordering
    lat_mode = 0;
    r0 = n_resp;
    send(1'b1, 32'h30, 32'hAA);
    send(1'b0, 32'h30, 32'h0);
    send(1'b0, 32'h34, 32'h0);
    wait_idle(200);
    chk("t3_resp_count", n_resp - r0, 2);

    // Random mix across pointer wrap-around, with back-to-back push/pop
    for (int i = 0; i < 40; i++) begin
      bit          rw   = 1'($urandom_range(0, 1));
      logic [31:0] addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
      send(rw, addr, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle(500);

    // Reset while an access is in flight with three more queued
    stall = 1'b1;
    for (int i = 0; i < 4; i++) send(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * i), $urandom);
    repeat (2) @(negedge clk);
    do_reset();
    r0 = n_resp;
    send(1'b0, 32'h40, 32'h0);
    wait_idle(100);
    chk("t5_resp_after_reset", n_resp - r0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
